pwm_fade_sequencer: RTL and testbench

//  Multi-channel PWM generator with a per-channel fade (ramp) controller.

---
 rtl/pwm_fade_sequencer_if.sv | 30 +++
 rtl/pwm_fade_sequencer.sv | 110 +++++++++++
 tb/tb_pwm_fade_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_fade_sequencer_if.sv
// pwm_fade_sequencer_if
//   Configuration port for pwm_fade_sequencer: one {channel, target, step}
//   request per transfer, valid/ready handshake.
//   cfg_valid  : request valid (master -> slave)
//   cfg_ready  : slave can accept (slave -> master)
//   cfg_ch     : channel index
//   cfg_target : requested final duty in clk cycles per period
//   cfg_step   : duty increment per ramp step, 0 = jump straight to target
interface pwm_fade_sequencer_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CW   = 8
) ();
    localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_target;
    logic [CW-1:0]  cfg_step;

    modport master (
        output cfg_valid, cfg_ch, cfg_target, cfg_step,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_target, cfg_step,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
//   Multi-channel PWM generator. Each channel's duty walks toward a
//   configured target in fixed steps, updated only on period boundaries
//   every STEP_PERIODS periods, so a PWM period is never split.
//   clk         : clock
//   nrst_in     : asynchronous active-low reset
//   cfg         : configuration port (slave side of pwm_fade_sequencer_if)
//   pwm_out     : registered PWM outputs, one per channel
//   busy        : channel is ramping toward its target
//   period_tick : high on the last cycle of every PWM period
module pwm_fade_sequencer #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CW           = 8,
    parameter int unsigned PERIOD       = 100,
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic                    clk,
    input  logic                    nrst_in,
    pwm_fade_sequencer_if.slave     cfg,
    output logic [N_CH-1:0]         pwm_out,
    output logic [N_CH-1:0]         busy,
    output logic                    period_tick
);
    localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PW  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    typedef enum logic {IDLE, RAMP} ch_state_t;

    logic [CW-1:0] cnt;
    logic [PW-1:0] prescaler;
    logic          step_evt;
    logic          xfer;
    logic [CW-1:0] tgt_clamped;

    ch_state_t     state     [N_CH];
    logic [CW-1:0] duty      [N_CH];
    logic [CW-1:0] target    [N_CH];
    logic [CW-1:0] step      [N_CH];
    logic [CW:0]   diff      [N_CH];
    logic [CW-1:0] ramp_duty [N_CH];
    logic [N_CH-1:0] ramp_done;

    always_comb begin
        period_tick = (cnt == CW'(PERIOD - 1));
        step_evt    = period_tick && (prescaler == PW'(STEP_PERIODS - 1));
        xfer        = cfg.cfg_valid && cfg.cfg_ready;
        tgt_clamped = (cfg.cfg_target > CW'(PERIOD)) ? CW'(PERIOD) : cfg.cfg_target;
    end

    // Next duty for a ramping channel. When the remaining distance is no
    // more than one step the channel lands exactly on target, so the
    // add/subtract below can neither overshoot PERIOD nor underflow.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            diff[i] = ({1'b0, target[i]} >= {1'b0, duty[i]})
                    ? {1'b0, target[i]} - {1'b0, duty[i]}
                    : {1'b0, duty[i]} - {1'b0, target[i]};
            ramp_done[i] = (step[i] == '0) || (diff[i] <= {1'b0, step[i]});
            if (ramp_done[i])
                ramp_duty[i] = target[i];
            else if (target[i] > duty[i])
                ramp_duty[i] = duty[i] + step[i];
            else
                ramp_duty[i] = duty[i] - step[i];
        end
    end

    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            cnt           <= '0;
            prescaler     <= '0;
            cfg.cfg_ready <= 1'b0;
            pwm_out       <= '0;
            busy          <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state[i]  <= IDLE;
                duty[i]   <= '0;
                target[i] <= '0;
                step[i]   <= '0;
            end
        end else begin
            cfg.cfg_ready <= 1'b1;
            cnt <= period_tick ? '0 : cnt + 1'b1;
            if (period_tick)
                prescaler <= (prescaler == PW'(STEP_PERIODS - 1)) ? '0 : prescaler + 1'b1;

            for (int unsigned i = 0; i < N_CH; i++) begin
                pwm_out[i] <= (cnt < duty[i]);

                if (step_evt && state[i] == RAMP) begin
                    duty[i] <= ramp_duty[i];
                    if (ramp_done[i]) begin
                        state[i] <= IDLE;
                        busy[i]  <= 1'b0;
                    end
                end

                // Placed after the step so a transfer on a step_evt edge
                // wins: the step used the old target/step, the new values
                // and RAMP state take effect for the next step_evt.
                if (xfer && cfg.cfg_ch == CHW'(i)) begin
                    target[i] <= tgt_clamped;
                    step[i]   <= cfg.cfg_step;
                    state[i]  <= RAMP;
                    busy[i]   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb_pwm_fade_sequencer
//   Directed and randomized configuration traffic for pwm_fade_sequencer,
//   compared every cycle against a cycle-count based reference model.
module tb_pwm_fade_sequencer;
    localparam int N_CH = 4;
    localparam int CW   = 8;
    localparam int PER  = 100;
    localparam int SP   = 4;

    logic clk = 1'b0;
    logic nrst_in = 1'b0;
    logic [N_CH-1:0] pwm_out;
    logic [N_CH-1:0] busy;
    logic period_tick;

    pwm_fade_sequencer_if #(.N_CH(N_CH), .CW(CW)) cfg_if ();

    pwm_fade_sequencer #(.N_CH(N_CH), .CW(CW), .PERIOD(PER), .STEP_PERIODS(SP)) dut (
        .clk         (clk),
        .nrst_in     (nrst_in),
        .cfg         (cfg_if),
        .pwm_out     (pwm_out),
        .busy        (busy),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: e = number of clk edges since reset release. The counter
    // value before edge e+1 is e mod PER, and a ramp step happens on
    // every edge whose number is a multiple of PER*SP.
    int e;
    int m_duty [N_CH];
    int m_tgt  [N_CH];
    int m_step [N_CH];
    bit m_ramp [N_CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s e=%0d got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask

    task automatic model_reset();
        e = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_duty[i] = 0; m_tgt[i] = 0; m_step[i] = 0; m_ramp[i] = 0;
        end
    endtask

    // One clock cycle: called just after a negedge with inputs set.
    task automatic cyc();
        logic [N_CH-1:0] exp_pwm;
        logic [N_CH-1:0] exp_busy;
        bit ready_before;
        int d;
        ready_before = (e >= 1);
        for (int i = 0; i < N_CH; i++)
            exp_pwm[i] = ((e % PER) < m_duty[i]);
        @(posedge clk);
        e++;
        if (e % (PER * SP) == 0) begin
            for (int i = 0; i < N_CH; i++) begin
                if (m_ramp[i]) begin
                    d = m_tgt[i] - m_duty[i];
                    if (d < 0) d = -d;
                    if (m_step[i] == 0 || d <= m_step[i]) begin
                        m_duty[i] = m_tgt[i];
                        m_ramp[i] = 0;
                    end else if (m_tgt[i] > m_duty[i]) begin
                        m_duty[i] += m_step[i];
                    end else begin
                        m_duty[i] -= m_step[i];
                    end
                end
            end
        end
        if (cfg_if.cfg_valid && ready_before) begin
            m_tgt[cfg_if.cfg_ch]  = (int'(cfg_if.cfg_target) > PER) ? PER : int'(cfg_if.cfg_target);
            m_step[cfg_if.cfg_ch] = int'(cfg_if.cfg_step);
            m_ramp[cfg_if.cfg_ch] = 1;
        end
        for (int i = 0; i < N_CH; i++) exp_busy[i] = m_ramp[i];
        @(negedge clk);
        chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("period_tick", 32'(period_tick), 32'((e % PER) == PER - 1));
        chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'h1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic send(input int ch, input int tgt, input int stp);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 2'(ch);
        cfg_if.cfg_target = 8'(tgt);
        cfg_if.cfg_step   = 8'(stp);
        cyc();
        cfg_if.cfg_valid  = 1'b0;
    endtask

    // Advance until the next clock edge is a ramp step edge.
    task automatic align_to_step();
        while ((e + 1) % (PER * SP) != 0) cyc();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pwm"}, 32'(pwm_out), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_tick"}, 32'(period_tick), 32'h0);
        chk({tag, "_ready"}, 32'(cfg_if.cfg_ready), 32'h0);
    endtask

    initial begin
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_target = '0;
        cfg_if.cfg_step   = '0;
        model_reset();

        // Reset held
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        // Release between edges; ready rises on the first edge
        nrst_in = 1'b1;
        run(250);

        // Jump to 40 on ch0
        send(0, 40, 0);
        run(700);

        // Ramp ch1 0 -> 30 in steps of 10, then retarget at duty 20
        align_to_step();
        send(1, 30, 10);
        run(400 * 2 + 5);
        chk("ch1_duty20", 32'(m_duty[1]), 32'd20);
        send(1, 0, 15);
        run(400 * 3);

        // Clamp to PERIOD on ch2
        send(2, 200, 0);
        run(500);

        // Transfer on the step edge: ch3 ramps with step 10, then
        // a new step arrives exactly on a step edge
        align_to_step();
        send(3, 90, 10);
        run(398);
        align_to_step();
        send(3, 5, 30);
        run(400 * 5);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int stp;
            stp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            send(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 255)), stp);
            run(int'($urandom_range(0, 300)));
        end

        // Reset mid-ramp, asserted between clock edges
        send(0, 100, 5);
        send(1, 0, 3);
        run(450);
        #2 nrst_in = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        chk_reset_outputs("rst_held");
        model_reset();
        nrst_in = 1'b1;
        run(900);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound in case of a stuck simulation
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout checks=%0d required=finish", checks);
        $fatal(1, "timeout");
    end
endmodule
